// File: rtl/spi_master_tx_if.sv
// Byte-stream and SPI pin bundle for the lamp-link SPI mode-0 transmitter.
// master = transmitter side; slave = the upstream sequencer / SPI receiver view.
interface spi_master_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_ready;
   logic       sck;
   logic       mosi;
   logic       cs;
   logic       busy;
   logic       byte_done;
   logic       frame_done;

   modport master (
      input  tx_data, tx_valid, tx_last,
      output tx_ready, sck, mosi, cs, busy, byte_done, frame_done
   );

   modport slave (
      output tx_data, tx_valid, tx_last,
      input  tx_ready, sck, mosi, cs, busy, byte_done, frame_done
   );
endinterface

// File: rtl/spi_master_tx.sv
// SPI mode-0 (CPOL=0, CPHA=0) master transmitter, MSB first, with byte-level
// valid/ready input and a last tag that closes the cs-low frame.
module spi_master_tx #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic            clk,
   input  logic            reset,
   spi_master_tx_if.master bus,
   output logic [2:0]      o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_HIGH   = 3'd2,
      S_LOW    = 3'd3,
      S_WAIT   = 3'd4,
      S_HOLD   = 3'd5,
      S_CSHIGH = 3'd6
   } state_t;

   localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_shift;
   logic [7:0] r_div;
   logic [2:0] r_bit_cnt;
   logic       r_last;
   logic       r_byte_done;
   logic       r_frame_done;

   logic       w_ready;
   logic       w_accept;
   logic       w_div_zero;
   logic       w_shift;
   logic       w_cnt_inc;
   logic       w_byte_end;
   logic       w_frame_end;

   // Handshake: a byte transfers on any rising clk edge where tx_valid and
   // tx_ready are both high; tx_ready is high only in IDLE and WAIT, and
   // tx_valid in any other state is ignored (nothing is queued).
   assign w_ready    = (r_state == S_IDLE) || (r_state == S_WAIT);
   assign w_accept   = bus.tx_valid && w_ready;
   assign w_div_zero = (r_div == 8'd0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_shift     = 1'b0;
      w_cnt_inc   = 1'b0;
      w_byte_end  = 1'b0;
      w_frame_end = 1'b0;
      case (r_state)
         S_IDLE, S_WAIT: if (w_accept) w_next = S_SETUP;
         S_SETUP:        if (w_div_zero) w_next = S_HIGH;
         S_HIGH: begin
            // Shifting on the HIGH->LOW step makes mosi change with the sck fall.
            if (w_div_zero) begin
               w_next  = S_LOW;
               w_shift = (r_bit_cnt != 3'd7);
            end
         end
         S_LOW: begin
            if (w_div_zero) begin
               if (r_bit_cnt != 3'd7) begin
                  w_cnt_inc = 1'b1;
                  w_next    = S_HIGH;
               end else begin
                  w_byte_end = 1'b1;
                  w_next     = r_last ? S_HOLD : S_WAIT;
               end
            end
         end
         S_HOLD:   if (w_div_zero) w_next = S_CSHIGH;
         S_CSHIGH: begin
            if (w_div_zero) begin
               w_frame_end = 1'b1;
               w_next      = S_IDLE;
            end
         end
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shift      <= 8'd0;
         r_div        <= 8'd0;
         r_bit_cnt    <= 3'd0;
         r_last       <= 1'b0;
         r_byte_done  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_byte_done  <= w_byte_end;
         r_frame_done <= w_frame_end;
         if (w_next != r_state)  r_div <= DIV_RELOAD;
         else if (!w_div_zero)   r_div <= r_div - 8'd1;
         if (w_accept) begin
            r_shift <= bus.tx_data;
            r_last  <= bus.tx_last;
         end else if (w_shift) begin
            r_shift <= {r_shift[6:0], 1'b0};
         end
         if (w_byte_end)     r_bit_cnt <= 3'd0;
         else if (w_cnt_inc) r_bit_cnt <= r_bit_cnt + 3'd1;
      end
   end

   // Pins decode straight from registered state so they cannot glitch.
   assign bus.tx_ready   = w_ready;
   assign bus.sck        = (r_state == S_HIGH);
   assign bus.cs         = (r_state == S_IDLE) || (r_state == S_CSHIGH);
   assign bus.mosi       = r_shift[7];
   assign bus.busy       = (r_state != S_IDLE);
   assign bus.byte_done  = r_byte_done;
   assign bus.frame_done = r_frame_done;
   assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_spi_master_tx.sv
// Randomized and directed bench for spi_master_tx: an SPI receiver model
// rebuilds bytes from the pins and is scored against the bytes handed in.
module tb_spi_master_tx;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] dbg_state;

   spi_master_tx_if bus ();

   spi_master_tx #(.CLK_DIV(D)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus.master),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   logic [7:0] frame_q[$];

   // receiver model and pin statistics, sampled on the falling clk edge
   int   bd_cnt = 0, fd_cnt = 0, cs_rises = 0, total_rises = 0;
   int   low_run = 0, high_run = 0, last_cs_low = 0, last_cs_high = 0;
   int   rises_in_frame = 0, first_rise_at = 0, rx_bits = 0;
   int   mosi_age = 0, mosi_bad = 0, fd_bad = 0;
   logic prev_cs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;
   logic [7:0] rx_sh = 8'd0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         prev_cs = 1'b1; prev_sck = 1'b0; prev_mosi = 1'b0;
         rx_bits = 0; low_run = 0; high_run = 0; mosi_age = 0;
      end else begin
         if (bus.mosi != prev_mosi) mosi_age = 1;
         else                       mosi_age++;
         bd_cnt += int'(bus.byte_done);
         if (bus.frame_done) begin
            fd_cnt++;
            if (!bus.tx_ready || bus.busy) fd_bad++;
         end
         if (!bus.cs) begin
            if (prev_cs) begin
               last_cs_high = high_run;
               low_run = 0;
               rises_in_frame = 0;
            end
            low_run++;
            if (bus.sck && !prev_sck) begin
               rises_in_frame++;
               total_rises++;
               if (rises_in_frame == 1) first_rise_at = low_run;
               // mosi must have been stable for a full half-period before the rise
               if (mosi_age < D + 1) mosi_bad++;
               rx_sh = {rx_sh[6:0], bus.mosi};
               rx_bits++;
               if (rx_bits == 8) begin
                  rx_q.push_back(rx_sh);
                  rx_bits = 0;
               end
            end
         end else begin
            if (!prev_cs) begin
               last_cs_low = low_run;
               cs_rises++;
               high_run = 0;
            end
            high_run++;
            rx_bits = 0;
         end
         prev_cs = bus.cs; prev_sck = bus.sck; prev_mosi = bus.mosi;
      end
   end

   task automatic send_byte(input logic [7:0] d, input logic l);
      int t = 0;
      @(negedge clk);
      bus.tx_data = d; bus.tx_last = l; bus.tx_valid = 1'b1;
      while (!bus.tx_ready && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      exp_q.push_back(d);
   endtask

   task automatic drop_valid();
      @(negedge clk);
      bus.tx_valid = 1'b0;
   endtask

   task automatic wait_frames(input int target);
      int t = 0;
      while (fd_cnt < target && t < 5000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 5000) check("frame_timeout", 32'd0, 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_rx(input string tag);
      check({tag, "_rx_count"}, rx_q.size(), exp_q.size());
      while (exp_q.size() > 0 && rx_q.size() > 0)
         check({tag, "_rx_byte"}, rx_q.pop_front(), exp_q.pop_front());
      exp_q.delete();
      rx_q.delete();
   endtask

   // Frame of frame_q bytes with tx_valid held, so each WAIT lasts one cycle.
   task automatic run_frame(input string tag);
      int n   = frame_q.size();
      int bd0 = bd_cnt;
      int fd0 = fd_cnt;
      int cr0 = cs_rises;
      int rr0 = total_rises;
      for (int i = 0; i < n; i++) send_byte(frame_q[i], (i == n - 1));
      drop_valid();
      wait_frames(fd0 + 1);
      check({tag, "_cs_low"}, last_cs_low, n * 17 * D + (n - 1) + D);
      check({tag, "_byte_done"}, bd_cnt - bd0, n);
      check({tag, "_frame_done"}, fd_cnt - fd0, 1);
      check({tag, "_cs_rises"}, cs_rises - cr0, 1);
      check({tag, "_sck_rises"}, total_rises - rr0, 8 * n);
      check({tag, "_first_rise"}, first_rise_at, D + 1);
      check_rx(tag);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int   bd0, fd0, t, bad;
      logic m0;
      bus.tx_valid = 1'b0; bus.tx_data = 8'd0; bus.tx_last = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("rst_cs", bus.cs, 1'b1);
      check("rst_sck", bus.sck, 1'b0);
      check("rst_mosi", bus.mosi, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_byte_done", bus.byte_done, 1'b0);
      check("rst_frame_done", bus.frame_done, 1'b0);
      check("rst_tx_ready", bus.tx_ready, 1'b1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      frame_q = '{8'hA5};
      run_frame("single_a5");

      frame_q = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h55, 8'hAA, 8'h3C};
      run_frame("seven");

      // back-pressure after the second byte
      fd0 = fd_cnt; bd0 = bd_cnt;
      send_byte(8'h96, 1'b0);
      send_byte(8'h3B, 1'b0);
      drop_valid();
      t = 0;
      while (bd_cnt < bd0 + 2 && t < 3000) begin @(negedge clk); t++; end
      check("bp_wait_timeout", (t < 3000), 1'b1);
      @(negedge clk);
      m0 = bus.mosi;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.cs !== 1'b0 || bus.sck !== 1'b0 || bus.mosi !== m0 || bus.tx_ready !== 1'b1) bad++;
         @(negedge clk);
      end
      check("bp_gap_pins", bad, 0);
      check("bp_gap_mosi", m0, 1'b1);
      send_byte(8'hE7, 1'b1);
      drop_valid();
      wait_frames(fd0 + 1);
      check("bp_frame_done", fd_cnt - fd0, 1);
      check_rx("bp");

      // tx_valid during HIGH must be ignored
      fd0 = fd_cnt; bd0 = bd_cnt;
      send_byte(8'hF0, 1'b1);
      drop_valid();
      t = 0;
      while (!bus.sck && t < 1000) begin @(negedge clk); t++; end
      bus.tx_data = 8'h00; bus.tx_valid = 1'b1;
      check("busy_tx_ready", bus.tx_ready, 1'b0);
      @(negedge clk);
      bus.tx_valid = 1'b0;
      wait_frames(fd0 + 1);
      repeat (20) @(negedge clk);
      check("busy_byte_done", bd_cnt - bd0, 1);
      check("busy_frame_done", fd_cnt - fd0, 1);
      check_rx("busy");

      // reset in the middle of bit 3
      fd0 = fd_cnt;
      send_byte(8'hC3, 1'b1);
      drop_valid();
      t = 0;
      while (rises_in_frame < 4 && t < 1000) begin @(negedge clk); t++; end
      #1 reset = 1'b0;
      #1;
      check("mid_rst_cs", bus.cs, 1'b1);
      check("mid_rst_sck", bus.sck, 1'b0);
      check("mid_rst_mosi", bus.mosi, 1'b0);
      check("mid_rst_busy", bus.busy, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      check("mid_rst_no_frame_done", fd_cnt - fd0, 0);
      check("mid_rst_no_rx", rx_q.size(), 0);
      exp_q.delete();
      frame_q = '{8'h5A};
      run_frame("after_rst");

      // back-to-back single-byte frames with tx_valid held
      fd0 = fd_cnt;
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      drop_valid();
      wait_frames(fd0 + 2);
      check("b2b_frames", fd_cnt - fd0, 2);
      check("b2b_cs_high", last_cs_high, D + 1);
      check("b2b_cs_low", last_cs_low, 18 * D);
      check_rx("b2b");

      for (int f = 0; f < 6; f++) begin
         int n = $urandom_range(1, 4);
         frame_q.delete();
         for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom_range(0, 255)));
         run_frame("rand");
      end

      check("mosi_setup_time", mosi_bad, 0);
      check("frame_done_with_ready", fd_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/spi_master_tx.md
# spi_master_tx

SPI mode-0 master transmitter: the sending end of the lamp's SPI link. It serialises a byte stream onto `sck`/`mosi`/`cs`, MSB first. It lives in the companion controller or test harness that drives the RGBW lamp's `spiSlave`. It has a byte-level valid/ready input with a `tx_last` tag that closes the frame, so an upstream sequencer can push a full lamp command frame (mode, intensity, colour, white bytes) inside one `cs`-low window.

## Interface
Parameters:
- `CLK_DIV`, default 4: `clk` cycles per `sck` half-period. Legal range is 2..255. Keep it ≥4 when driving a receiver that oversamples `sck` with its own `clk`.

Ports:
- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `tx_data` in 8: byte to send, MSB first.
- `tx_valid` in 1: `tx_data`/`tx_last` valid.
- `tx_last` in 1: the accepted byte is the last byte of the frame.
- `tx_ready` out 1: block can accept a byte this cycle.
- `sck` out 1: SPI clock; idles low (CPOL=0).
- `mosi` out 1: serial data; changes on `sck` falling edge.
- `cs` out 1: chip select, active low.
- `busy` out 1: high whenever the state is not IDLE.
- `byte_done` out 1: one-cycle pulse after a byte's 8th `sck` falling edge.
- `frame_done` out 1: one-cycle pulse on return to IDLE after a frame.

## Operation
- Reset (async, `reset`=0):
  - state=IDLE; `cs`=1, `sck`=0, `mosi`=0.
  - `busy`=0, `byte_done`=0, `frame_done`=0; `tx_ready`=1.
  - Shift register, bit counter and divider counter are cleared.
- Accept rule: a byte is accepted when `tx_valid & tx_ready` at a `clk` edge. `tx_data` is loaded into an 8-bit shift register and `tx_last` into a last flag.
- `tx_ready`=1 only in IDLE and WAIT; it is 0 in every other state. `tx_valid` outside those states is ignored; nothing is queued.
- States:
  - IDLE: `cs`=1, `sck`=0. On accept → SETUP.
  - SETUP: `cs`=0, `mosi`=shift[7], `sck`=0, for `CLK_DIV` cycles → HIGH.
  - HIGH: `sck`=1 for `CLK_DIV` cycles → LOW.
    - If bit counter < 7: shift left by one, so `mosi` takes the next bit at the falling edge.
  - LOW: `sck`=0 for `CLK_DIV` cycles.
    - If bit counter < 7: increment it → HIGH.
    - Else: pulse `byte_done` and clear the bit counter; → HOLD if the last flag is set, otherwise → WAIT.
  - WAIT: `cs`=0, `sck`=0, `mosi` holds the last bit. Waits indefinitely for an accept; on accept → SETUP.
  - HOLD: `cs`=0, `sck`=0 for `CLK_DIV` cycles → CSHIGH.
  - CSHIGH: `cs`=1 for `CLK_DIV` cycles; pulse `frame_done` on exit → IDLE.
- Divider: a counter from `CLK_DIV`-1 down to 0. The state advances on the cycle the counter reaches 0, and the counter reloads on every state change.
- Widths: the bit counter is 3 bits and never wraps past 7. The divider counter is 8 bits.
- Reset mid-operation: the outputs return asynchronously to their reset values (`cs` rises immediately). Any partial byte is discarded, and `frame_done` is not pulsed.
- Simultaneous events: in WAIT, an accept on the same cycle the state is entered (the cycle after `byte_done`) is legal. `cs` stays low throughout.

## Timing
All figures assume the accept occurs at cycle 0.
- `cs` falls at cycle 1.
- The first `sck` rise is at cycle 1+`CLK_DIV`. `mosi` is stable for ≥`CLK_DIV` cycles before every rising edge.
- Byte time from SETUP entry to `byte_done` is 17·`CLK_DIV` cycles.
- Single-byte frame: `cs` is low for exactly 18·`CLK_DIV` cycles.
- Minimum `cs`-high time between frames is `CLK_DIV`+1 cycles (CSHIGH plus one IDLE cycle for the accept).
- Between bytes in a frame, `sck` low time is ≥2·`CLK_DIV`+1 cycles (LOW + WAIT ≥1 cycle + SETUP).
- `frame_done` is asserted on the first IDLE cycle. `tx_ready` is high in that same cycle.
- All outputs are registered, or decoded directly from registered state, so they are glitch-free.

## Test plan
- Single byte, `CLK_DIV`=4, `tx_data`=0xA5, `tx_last`=1:
  - `cs` low for 72 cycles; exactly 8 `sck` rising edges.
  - Bits sampled on `sck` rise are 1,0,1,0,0,1,0,1.
  - One `byte_done` and one `frame_done` pulse.
- 7-byte frame 0x01,0x80,0xFF,0x00,0x55,0xAA,0x3C with `tx_last` on the 7th byte, looped into a `spiSlave`-equivalent model:
  - The model receives the same 7 bytes in order.
  - `cs` stays low across the whole frame; 7 `byte_done` pulses.
- Back-pressure: withhold `tx_valid` for 20 cycles after the 2nd `byte_done`.
  - During the gap: `cs`=0, `sck`=0, `mosi` stable, `tx_ready`=1.
  - The 3rd byte is sent correctly once `tx_valid` returns.
- Busy ignore: pulse `tx_valid` with 0x00 during HIGH of byte 0xF0.
  - `tx_ready`=0 at that time; 0xF0 is sent unaltered; no extra byte is transmitted.
- Reset mid-byte: drive `reset`=0 during bit 3 of 0xC3.
  - `cs`=1, `sck`=0, `mosi`=0 within the same cycle; no `frame_done`.
  - After release, a new 0x5A frame transmits correctly.
- Back-to-back frames 0x11 then 0x22 with `tx_valid` held high:
  - `cs` is high for exactly `CLK_DIV`+1 cycles between the frames.
  - Both bytes are received intact.
